// File: rtl/reg_writeback_unit_pkg.sv
// Shared types and helpers for the register writeback stage.
package reg_writeback_unit_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    // One pending register write: destination plus result value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Decode a destination register number into a one-hot register mask.
    function automatic logic [NUM_REGS-1:0] onehot_dst(input logic [REG_ADDR_W-1:0] dst);
        logic [NUM_REGS-1:0] mask;
        mask      = '0;
        mask[dst] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/reg_writeback_unit_queue.sv
// In-order writeback queue: up to two pushes and one pop per cycle, with
// per-entry valid bits and destinations exposed for hazard-mask generation.
module wb_queue
    import reg_writeback_unit_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           wrEn0_i,
    input  wb_entry_t                      wrEntry0_i,
    input  logic                           wrEn1_i,
    input  wb_entry_t                      wrEntry1_i,
    input  logic                           rdEn_i,
    output logic [$clog2(Depth+1)-1:0]     count_o,
    output wb_entry_t                      head_o,
    output logic [Depth-1:0]               entryValid_o,
    output logic [Depth-1:0][REG_ADDR_W-1:0] entryDst_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    wb_entry_t        entryQ [Depth];
    logic [Depth-1:0] validQ, validD;
    logic [PtrW-1:0]  wrPtrQ, wrPtrD;
    logic [PtrW-1:0]  rdPtrQ, rdPtrD;
    logic [CntW-1:0]  countQ, countD;
    logic [PtrW-1:0]  slot1;
    logic [CntW-1:0]  enqN;
    logic             doPop;

    // Next pointers, count and valid bits; the second push lands one slot after the first.
    always_comb begin
        doPop  = rdEn_i && (countQ != '0);
        enqN   = CntW'(wrEn0_i) + CntW'(wrEn1_i);
        slot1  = wrPtrQ + PtrW'(wrEn0_i);
        wrPtrD = wrPtrQ + PtrW'(enqN);
        rdPtrD = rdPtrQ + PtrW'(doPop);
        countD = countQ + enqN - CntW'(doPop);
        validD = validQ;
        if (doPop) begin
            validD[rdPtrQ] = 1'b0;
        end
        if (wrEn0_i) begin
            validD[wrPtrQ] = 1'b1;
        end
        if (wrEn1_i) begin
            validD[slot1] = 1'b1;
        end
    end

    // Control state: pointers, count and valid bits cleared by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
            validQ <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
            validQ <= validD;
        end
    end

    // Entry storage; contents are meaningless unless the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (wrEn0_i) begin
            entryQ[wrPtrQ] <= wrEntry0_i;
        end
        if (wrEn1_i) begin
            entryQ[slot1] <= wrEntry1_i;
        end
    end

    // Flatten per-entry destinations for the pending-register mask.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            entryDst_o[i] = entryQ[i].dst;
        end
    end

    assign count_o      = countQ;
    assign head_o       = entryQ[rdPtrQ];
    assign entryValid_o = validQ;

    // Producers must never be granted more slots than remain free.
    assert property (@(posedge clk_i) disable iff (reset_i) (int'(countQ) + int'(enqN)) <= Depth);

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage feeding the register bank write port. Merges ALU and load
// results into an in-order queue, retires one write per cycle, and reports
// which registers still have writes in flight.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int DataWidth = DATA_W,
    parameter int AddrWidth = REG_ADDR_W,
    parameter int Depth     = 4
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [AddrWidth-1:0]         alu_dst,
    input  logic [DataWidth-1:0]         alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [AddrWidth-1:0]         mem_dst,
    input  logic [DataWidth-1:0]         mem_data,
    output logic [DataWidth-1:0]         WriteData,
    output logic                         WriteRegister,
    output logic [AddrWidth-1:0]         WriteRegisterAddress,
    output logic [2**AddrWidth-1:0]      pending_mask,
    output logic [$clog2(Depth+1)-1:0]   occupancy
);

    localparam int CntW  = $clog2(Depth + 1);
    localparam int MaskW = 2 ** AddrWidth;

    logic                 memPush, aluPush;
    logic                 wrEn0, wrEn1;
    wb_entry_t            memEntry, aluEntry, wrEntry0;
    wb_entry_t            head;
    logic                 pop;
    logic [Depth-1:0]     entryValid;
    logic [Depth-1:0][REG_ADDR_W-1:0] entryDst;
    logic [NUM_REGS-1:0]  maskAll;

    logic                 writeRegQ;
    logic [AddrWidth-1:0] writeAddrQ;
    logic [DataWidth-1:0] writeDataQ;

    // Readies depend only on the registered count and mem_valid, so a load
    // always gets the first free slot and the ALU needs a second one beside it.
    always_comb begin
        mem_ready = occupancy < CntW'(Depth);
        alu_ready = mem_valid ? (occupancy < CntW'(Depth - 1))
                              : (occupancy < CntW'(Depth));
    end

    // Steer accepted results into queue write slots, load first as the older instruction.
    always_comb begin
        memPush       = mem_valid && mem_ready;
        aluPush       = alu_valid && alu_ready;
        memEntry.dst  = REG_ADDR_W'(mem_dst);
        memEntry.data = DATA_W'(mem_data);
        aluEntry.dst  = REG_ADDR_W'(alu_dst);
        aluEntry.data = DATA_W'(alu_data);
        wrEn0         = memPush || aluPush;
        wrEn1         = memPush && aluPush;
        wrEntry0      = memPush ? memEntry : aluEntry;
        pop           = occupancy != '0;
    end

    wb_queue #(
        .Depth(Depth)
    ) uQueue (
        .clk_i        (CLK),
        .reset_i      (Reset),
        .wrEn0_i      (wrEn0),
        .wrEntry0_i   (wrEntry0),
        .wrEn1_i      (wrEn1),
        .wrEntry1_i   (aluEntry),
        .rdEn_i       (pop),
        .count_o      (occupancy),
        .head_o       (head),
        .entryValid_o (entryValid),
        .entryDst_o   (entryDst)
    );

    // Output register: present the popped head for one cycle, otherwise hold address/data.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            writeRegQ  <= 1'b0;
            writeAddrQ <= '0;
            writeDataQ <= '0;
        end else if (pop) begin
            writeRegQ  <= 1'b1;
            writeAddrQ <= AddrWidth'(head.dst);
            writeDataQ <= DataWidth'(head.data);
        end else begin
            writeRegQ  <= 1'b0;
        end
    end

    // Pending mask: every queued destination plus the write being presented now.
    always_comb begin
        maskAll = '0;
        for (int i = 0; i < Depth; i++) begin
            if (entryValid[i]) begin
                maskAll = maskAll | onehot_dst(entryDst[i]);
            end
        end
        if (writeRegQ) begin
            maskAll = maskAll | onehot_dst(REG_ADDR_W'(writeAddrQ));
        end
        pending_mask = MaskW'(maskAll);
    end

    assign WriteRegister        = writeRegQ;
    assign WriteRegisterAddress = writeAddrQ;
    assign WriteData            = writeDataQ;

endmodule
